beh_reset_sequencer: RTL and testbench
======================================

// Module: beh_reset_sequencer
// PURPOSE
//  Consumes the raw reset_n vector produced by the behavioural reset generator
//  (RESETS reset bits, then STARTS start bits, then DELAYS delay bits).
//  Synchronizes the vector into the clk domain and releases the resets first, then each start.
//  Releases are glitch-free, cycle-counted and in a fixed order.
//  Sits between the reset generator and the generated CSP process instances.
// PARAMETERS
//  RESETS       1     number of reset bits (low bits of in_reset_n)
//  STARTS       0     number of start bits (follow the reset bits)
//  DELAYS       0     number of delay bits (top bits; synchronized, passed through)
//  SYNC_STAGES  2     synchronizer depth, >=2
//  RESET_HOLD   4     cycles out_reset_n stays low after the synced reset bits are all high, >=1
//  START_GAP    2     cycles between out_reset_n release and the first start, and between starts, >=1
//  WDOG_CYCLES  1024  watchdog limit (only with the watchdog macro)
// PORTS
//  clk          in   1                      clock
//  reset        in   1                      synchronous, active-high
//  in_reset_n   in   RESETS+STARTS+DELAYS   raw upstream vector, async to clk
//  out_reset_n  out  RESETS                 sequenced resets, active-low
//  out_start_n  out  max(STARTS,1)          sequenced starts, active-low; tied 1 when STARTS==0
//  out_delay_n  out  max(DELAYS,1)          synchronized delay bits; tied 1 when DELAYS==0
//  ready        out  1                      1 in S_RUN only
//  timeout      out  1                      watchdog flag; exists only with the macro
// BEHAVIOUR
//  - reset=1 forces, on the next edge:
//    - sync flops to 0, state S_RESET, counters to 0;
//    - out_reset_n='0, out_start_n='0, out_delay_n='0, ready=0, timeout=0.
//  - Sync: each bit passes through SYNC_STAGES flops; FSM acts on the last stage only.
//  - rst_ok = &sync[RESETS-1:0]; start bit i uses sync[RESETS+i].
//  - S_RESET:
//    - all outputs low;
//    - when rst_ok, go to S_HOLD with cnt=0.
//  - S_HOLD:
//    - cnt increments each cycle;
//    - at cnt==RESET_HOLD-1, out_reset_n<='1 and cnt<=0;
//    - next state is S_START if STARTS>0, else S_RUN.
//  - S_START (index idx, starting at 0):
//    - cnt counts to START_GAP-1; then, if sync[RESETS+idx]==1:
//      out_start_n[idx]<=1, idx++, cnt<=0;
//    - if the synced start bit is still low, wait with cnt saturated;
//      release on the first cycle it is high.
//    - Starts release strictly in ascending index, one per edge maximum.
//    - After idx==STARTS-1 is released, go to S_RUN.
//  - S_RUN: ready=1 (registered, rises on the same edge as the last release).
//  - Boundary rules:
//    - Latency, defaults: in_reset_n reset bits high before edge 0
//      -> out_reset_n high after edge SYNC_STAGES+RESET_HOLD = 6.
//    - Re-assertion: rst_ok==0 in any state other than S_RESET -> next edge
//      clears all outputs and ready, and returns to S_RESET for a full re-sequence.
//    - An upstream start bit dropping after its release also forces S_RESET.
//    - A delay bit never affects the FSM; out_delay_n = synced bit AND (state==S_RUN).
//    - A single-cycle low pulse on an input bit shorter than one cycle may be missed.
//      A bit held low >= 1 cycle is always seen.
//    - The counter width is clog2(max(RESET_HOLD,START_GAP))+1; it never wraps.
// CONFIGURATION
//  CAST2VERILOG_RESET_SEQ_WATCHDOG_EN:
//  - defined: a counter runs whenever the state is not S_RUN;
//    - it clears on S_RUN and on reset;
//    - when it reaches WDOG_CYCLES, timeout latches to 1;
//    - timeout clears only on reset or on entry to S_RUN;
//    - the counter saturates.
//  - undefined: no counter; the timeout port is absent.
//    All other behaviour is identical, cycle for cycle.
// STRUCTURE
//  - cast2verilog_reset_pkg:
//    - seq_state_e {S_RESET, S_HOLD, S_START, S_RUN};
//    - function cnt_width(int a, int b);
//    - localparam MIN_SYNC_STAGES=2.
//  - Sub-module beh_reset_sync: a parameterized-width, SYNC_STAGES-deep synchronizer
//    with synchronous active-high clear to 0. Instantiated once over the full vector.
//  - Parameter checks (SYNC_STAGES>=2, RESET_HOLD>=1, START_GAP>=1) are
//    elaboration-time $error calls.
// TESTING
//  1. Defaults, RESETS=1, STARTS=0; hold reset 3 cycles, in_reset_n=1
//     -> out_reset_n rises 6 edges after reset drops; ready rises on the same edge.
//  2. RESETS=2, STARTS=3, in_reset_n all 1
//     -> resets rise at edge 6; starts 0/1/2 rise at edges 8/10/12; ready at 12.
//  3. STARTS=2, start bit 1 held low until edge 20
//     -> start 0 rises at edge 8; start 1 rises at edge 20+SYNC_STAGES (=22), not earlier.
//  4. In S_RUN, drop reset bit 0 for 4 cycles
//     -> all outputs low 3 edges after the drop (2 sync + 1);
//     -> after release, the full sequence repeats with the same latencies.
//  5. Assert reset mid-S_START (after start 0 has been released)
//     -> next edge: all outputs 0, state S_RESET; no start glitches high afterwards.
//  6. With the watchdog macro, WDOG_CYCLES=16, in_reset_n held 0
//     -> timeout=1 at edge 16, stays 1; releasing the inputs -> timeout clears when ready rises.

Source files
------------

// File: rtl/cast2verilog_reset_pkg.sv
// Shared types and helpers for the behavioural reset sequencer.
package cast2verilog_reset_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } seq_state_e;

    // Width able to hold max(a,b)-1 with one spare bit so the counter never wraps.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) m = 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/beh_reset_sync.sv
// Multi-stage flop synchronizer for a raw, asynchronous vector; clears to 0.
module beh_reset_sync
    import cast2verilog_reset_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            stg_q <= '0;
        end else begin
            stg_q <= {stg_q[STAGES-2:0], d};
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/beh_reset_sequencer.sv
// Synchronizes the upstream reset/start/delay vector and releases resets, then starts, in order.
// Optional watchdog: define CAST2VERILOG_RESET_SEQ_WATCHDOG_EN to add the timeout port.
module beh_reset_sequencer
    import cast2verilog_reset_pkg::*;
#(
    parameter int unsigned RESETS      = 1,
    parameter int unsigned STARTS      = 0,
    parameter int unsigned DELAYS      = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_HOLD  = 4,
    parameter int unsigned START_GAP   = 2,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [RESETS+STARTS+DELAYS-1:0]           in_reset_n,
    output logic [RESETS-1:0]                         out_reset_n,
    output logic [((STARTS > 0) ? STARTS : 1)-1:0]    out_start_n,
    output logic [((DELAYS > 0) ? DELAYS : 1)-1:0]    out_delay_n,
    output logic                                      ready
`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
    ,
    output logic                                      timeout
`endif
);

    localparam int unsigned TW       = RESETS + STARTS + DELAYS;
    localparam int unsigned SW       = (STARTS > 0) ? STARTS : 1;
    localparam int unsigned DW       = (DELAYS > 0) ? DELAYS : 1;
    localparam int unsigned CW       = cnt_width(RESET_HOLD, START_GAP);
    localparam int unsigned IW       = (SW > 1) ? $clog2(SW) : 1;
    localparam int unsigned LAST_IDX = (STARTS > 0) ? STARTS - 1 : 0;

    // Absent start/delay lanes idle high so the outputs read as tied to 1.
    localparam logic [SW-1:0] START_IDLE = {SW{STARTS == 0}};
    localparam logic [DW-1:0] DELAY_IDLE = {DW{DELAYS == 0}};

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
        $error("beh_reset_sequencer: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (RESET_HOLD < 1) begin : g_chk_hold
        $error("beh_reset_sequencer: RESET_HOLD must be >= 1");
    end
    if (START_GAP < 1) begin : g_chk_gap
        $error("beh_reset_sequencer: START_GAP must be >= 1");
    end
    if (WDOG_CYCLES < 1) begin : g_chk_wdog
        $error("beh_reset_sequencer: WDOG_CYCLES must be >= 1");
    end

    logic [TW-1:0] sync_q;
    logic [SW-1:0] start_sync;
    logic [DW-1:0] delay_sync;
    logic          rst_ok;

    beh_reset_sync #(
        .WIDTH  (TW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .clear (reset),
        .d     (in_reset_n),
        .q     (sync_q)
    );

    assign rst_ok = &sync_q[RESETS-1:0];

    if (STARTS > 0) begin : g_start_sync
        assign start_sync = sync_q[RESETS +: STARTS];
    end else begin : g_no_start_sync
        assign start_sync = '1;
    end

    if (DELAYS > 0) begin : g_delay_sync
        assign delay_sync = sync_q[RESETS+STARTS +: DELAYS];
    end else begin : g_no_delay_sync
        assign delay_sync = '1;
    end

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RESETS-1:0] rst_q, rst_d;
    logic [SW-1:0] start_q, start_d;
    logic [DW-1:0] delay_q, delay_d;
    logic          ready_d;
    logic          cur_start;
    logic          abort;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        start_d   = start_q;
        cur_start = 1'b0;
        abort     = 1'b0;

        for (int i = 0; i < int'(SW); i++) begin
            if (idx_q == IW'(i)) cur_start = start_sync[i];
        end

        // Losing a reset bit, or a start bit already released, forces a full re-sequence.
        abort = (state_q != S_RESET) && (!rst_ok || (|(start_q & ~start_sync)));

        if (abort) begin
            state_d = S_RESET;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            start_d = START_IDLE;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    start_d = START_IDLE;
                    if (rst_ok) state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (cnt_q == CW'(RESET_HOLD - 1)) begin
                        rst_d   = '1;
                        cnt_d   = '0;
                        state_d = (STARTS > 0) ? S_START : S_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_START: begin
                    if (cnt_q != CW'(START_GAP - 1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (cur_start) begin
                        for (int i = 0; i < int'(SW); i++) begin
                            if (idx_q == IW'(i)) start_d[i] = 1'b1;
                        end
                        cnt_d = '0;
                        if (idx_q == IW'(LAST_IDX)) begin
                            idx_d   = '0;
                            state_d = S_RUN;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end

        ready_d = (state_d == S_RUN);
        delay_d = (state_d == S_RUN) ? delay_sync : DELAY_IDLE;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            start_q <= START_IDLE;
            delay_q <= DELAY_IDLE;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            start_q <= start_d;
            delay_q <= delay_d;
            ready   <= ready_d;
        end
    end

    assign out_reset_n = rst_q;
    assign out_start_n = start_q;
    assign out_delay_n = delay_q;

`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_d;

    // Saturating count of cycles spent outside S_RUN; flag latches until S_RUN entry.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout;
        if (state_d == S_RUN) begin
            wdog_d    = '0;
            timeout_d = 1'b0;
        end else if (state_q != S_RUN) begin
            if (wdog_q == WW'(WDOG_CYCLES)) begin
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q  <= '0;
            timeout <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            timeout <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_beh_reset_sequencer.sv
// Randomized bench for beh_reset_sequencer against an event-time reference model.
module tb_beh_reset_sequencer;

    localparam int unsigned RESETS      = 2;
    localparam int unsigned STARTS      = 3;
    localparam int unsigned DELAYS      = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RESET_HOLD  = 4;
    localparam int unsigned START_GAP   = 2;
    localparam int unsigned WDOG_CYCLES = 16;
    localparam int unsigned N           = RESETS + STARTS + DELAYS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      in_reset_n = '1;
    logic [RESETS-1:0] out_reset_n;
    logic [STARTS-1:0] out_start_n;
    logic [DELAYS-1:0] out_delay_n;
    logic              ready;
`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
    logic              timeout;
`endif

    always #5 clk = ~clk;

    beh_reset_sequencer #(
        .RESETS      (RESETS),
        .STARTS      (STARTS),
        .DELAYS      (DELAYS),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_HOLD  (RESET_HOLD),
        .START_GAP   (START_GAP),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_reset_n  (in_reset_n),
        .out_reset_n (out_reset_n),
        .out_start_n (out_start_n),
        .out_delay_n (out_delay_n),
        .ready       (ready)
`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
        ,
        .timeout     (timeout)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: inputs reach the sequencer SYNC_STAGES edges late; releases are
    // scheduled as absolute edge times (hold after rst_ok, then one gap per start).
    logic [N-1:0]      pipe[$];
    int                cyc     = 0;
    bit                m_busy  = 1'b0;
    int                m_nrel  = -1;
    int                m_next  = 0;
    logic [RESETS-1:0] e_reset = '0;
    logic [STARTS-1:0] e_start = '0;
    logic [DELAYS-1:0] e_delay = '0;
    logic              e_ready = 1'b0;
    int                m_wd    = 0;
    logic              e_to    = 1'b0;

    task automatic model_edge(input logic rst, input logic [N-1:0] v);
        logic [N-1:0]      seen;
        logic [STARTS-1:0] st;
        bit                ok;
        bit                drop;
        logic              prev_ready;
        prev_ready = e_ready;
        if (rst) begin
            pipe = {};
            for (int i = 0; i < int'(SYNC_STAGES); i++) pipe.push_back('0);
            m_busy = 1'b0;
            m_nrel = -1;
            m_wd   = 0;
            e_to   = 1'b0;
            e_reset = '0;
            e_start = '0;
            e_delay = '0;
            e_ready = 1'b0;
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(v);
        ok   = &seen[RESETS-1:0];
        st   = seen[RESETS +: STARTS];
        drop = 1'b0;
        for (int i = 0; i < int'(STARTS); i++) begin
            if (i < m_nrel && !st[i]) drop = 1'b1;
        end
        if (!m_busy) begin
            if (ok) begin
                m_busy = 1'b1;
                m_nrel = -1;
                m_next = cyc + int'(RESET_HOLD);
            end
        end else if (!ok || drop) begin
            m_busy = 1'b0;
            m_nrel = -1;
        end else if (cyc >= m_next && m_nrel < int'(STARTS)) begin
            if (m_nrel < 0) begin
                m_nrel = 0;
                m_next = cyc + int'(START_GAP);
            end else if (st[m_nrel]) begin
                m_nrel++;
                m_next = cyc + int'(START_GAP);
            end
        end
        e_reset = (m_busy && m_nrel >= 0) ? '1 : '0;
        for (int i = 0; i < int'(STARTS); i++) e_start[i] = m_busy && (i < m_nrel);
        e_ready = m_busy && (m_nrel == int'(STARTS));
        e_delay = e_ready ? seen[RESETS+STARTS +: DELAYS] : '0;
        if (e_ready) begin
            m_wd = 0;
            e_to = 1'b0;
        end else if (!prev_ready) begin
            if (m_wd == int'(WDOG_CYCLES)) e_to = 1'b1;
            else m_wd++;
        end
    endtask

    int edge_no = -1;
    int rise[5];

    // One clock: drive on the falling edge, advance the model, sample 1 unit after the rise.
    task automatic step(input logic rst, input logic [N-1:0] v);
        @(negedge clk);
        reset      = rst;
        in_reset_n = v;
        @(posedge clk);
        cyc++;
        model_edge(rst, v);
        #1;
        check_eq("out_reset_n", 32'(out_reset_n), 32'(e_reset));
        check_eq("out_start_n", 32'(out_start_n), 32'(e_start));
        check_eq("out_delay_n", 32'(out_delay_n), 32'(e_delay));
        check_eq("ready", 32'(ready), 32'(e_ready));
`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
        check_eq("timeout", 32'(timeout), 32'(e_to));
`endif
        if (rst) begin
            edge_no = -1;
            for (int i = 0; i < 5; i++) rise[i] = -1;
        end else begin
            edge_no++;
            if (rise[0] < 0 && (&out_reset_n)) rise[0] = edge_no;
            for (int i = 0; i < int'(STARTS); i++) begin
                if (rise[1+i] < 0 && out_start_n[i]) rise[1+i] = edge_no;
            end
            if (rise[4] < 0 && ready) rise[4] = edge_no;
        end
    endtask

    initial begin
        logic [N-1:0] v;
        int           d_edge;
        int           r_edge;
        int           fall;
        int           back;

        // Full release order with every input high.
        repeat (3) step(1'b1, '1);
        check_eq("reset_state", 32'({out_reset_n, out_start_n, out_delay_n, ready}), 32'(0));
        repeat (16) step(1'b0, '1);
        check_eq("lat_reset", 32'(rise[0]), 32'(6));
        check_eq("lat_start0", 32'(rise[1]), 32'(8));
        check_eq("lat_start1", 32'(rise[2]), 32'(10));
        check_eq("lat_start2", 32'(rise[3]), 32'(12));
        check_eq("lat_ready", 32'(rise[4]), 32'(12));

        // Start bit 1 held low until edge 20.
        v = '1;
        v[RESETS+1] = 1'b0;
        repeat (2) step(1'b1, v);
        for (int e = 0; e <= 30; e++) begin
            v[RESETS+1] = (e >= 20);
            step(1'b0, v);
        end
        check_eq("late_start0", 32'(rise[1]), 32'(8));
        check_eq("late_start1", 32'(rise[2]), 32'(22));
        check_eq("late_start2", 32'(rise[3]), 32'(24));
        check_eq("late_ready", 32'(rise[4]), 32'(24));

        // Reset bit 0 dropped for 4 cycles while running, then a full re-sequence.
        fall   = -1;
        back   = -1;
        d_edge = edge_no + 1;
        v = '1;
        v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, v);
            if (fall < 0 && !ready) fall = edge_no;
        end
        r_edge = edge_no + 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '1);
            if (fall < 0 && !ready) fall = edge_no;
            if (back < 0 && ready) back = edge_no;
        end
        check_eq("drop_fall", 32'(fall), 32'(d_edge + 2));
        check_eq("drop_reseq", 32'(back), 32'(r_edge + 12));

        // Reset asserted after start 0 released; nothing may glitch high afterwards.
        repeat (2) step(1'b1, '1);
        repeat (10) step(1'b0, '1);
        check_eq("mid_start0", 32'(out_start_n), 32'(1));
        step(1'b1, '1);
        check_eq("mid_clear", 32'({out_reset_n, out_start_n, out_delay_n, ready}), 32'(0));
        for (int k = 0; k < 6; k++) step(1'b0, '0);
        check_eq("mid_quiet", 32'(out_start_n), 32'(0));

`ifdef CAST2VERILOG_RESET_SEQ_WATCHDOG_EN
        // Watchdog: inputs held low, then released.
        fall = -1;
        back = -1;
        repeat (2) step(1'b1, '0);
        for (int k = 0; k < 22; k++) begin
            step(1'b0, '0);
            if (fall < 0 && timeout) fall = edge_no;
        end
        check_eq("wdog_set", 32'(fall), 32'(WDOG_CYCLES));
        for (int k = 0; k < 16; k++) begin
            step(1'b0, '1);
            if (back < 0 && ready) begin
                back = edge_no;
                check_eq("wdog_clear", 32'(timeout), 32'(0));
            end
        end
        check_eq("wdog_ready", 32'(back), 32'(22 + 12));
`endif

        // Randomized upstream behaviour with occasional synchronous resets.
        v = '1;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < int'(N); b++) begin
                if (v[b]) begin
                    if (b < int'(RESETS + STARTS)) v[b] = ($urandom_range(0, 199) != 0);
                    else                           v[b] = ($urandom_range(0, 9) != 0);
                end else begin
                    v[b] = ($urandom_range(0, 2) == 0);
                end
            end
            step(($urandom_range(0, 299) == 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
